// File: rtl/flash_arbiter_if.sv
// Bundle of the fetch, load and flash-array signals around flash_arbiter.
// slave is the arbiter's view; master is the view of everything around it.
interface flash_arbiter_if #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int FL_AW = 12
);
    logic             if_req;
    logic [AW-1:0]    if_addr;
    logic             if_rvalid;
    logic [DW-1:0]    if_rdata;
    logic             ld_req;
    logic [AW-1:0]    ld_addr;
    logic             ld_rvalid;
    logic [DW-1:0]    ld_rdata;
    logic             fl_en;
    logic [FL_AW-1:0] fl_addr;
    logic [DW-1:0]    fl_rdata;
    logic             busy;

    modport slave (
        input  if_req, if_addr, ld_req, ld_addr, fl_rdata,
        output if_rvalid, if_rdata, ld_rvalid, ld_rdata, fl_en, fl_addr, busy
    );

    modport master (
        output if_req, if_addr, ld_req, ld_addr, fl_rdata,
        input  if_rvalid, if_rdata, ld_rvalid, ld_rdata, fl_en, fl_addr, busy
    );
endinterface

// File: rtl/flash_arbiter.sv
// Round-robin arbiter sharing the single-port instruction flash between
// the fetch and load ports, one outstanding read at a time.
module flash_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int FL_AW    = 12,
    parameter int READ_LAT = 1
) (
    input  logic            clk,
    input  logic            reset,
    flash_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic {PORT_IF, PORT_LD} port_t;

    localparam logic [3:0] LAT_LOAD = 4'(READ_LAT - 1);

    state_t     state;
    port_t      owner;
    port_t      last_grant;
    logic [3:0] lat_cnt;
    logic       grant_ld;

    // A tie goes to whichever port was not served last.
    always_comb begin
        grant_ld = bus.ld_req && (!bus.if_req || last_grant == PORT_IF);
    end

    // Word index within the flash; low byte-offset bits and high wrap bits are dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.if_addr[AW-1:FL_AW+2], bus.if_addr[1:0],
                                bus.ld_addr[AW-1:FL_AW+2], bus.ld_addr[1:0]};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= PORT_IF;
            last_grant <= PORT_LD;
            lat_cnt    <= '0;
            bus.fl_en     <= 1'b0;
            bus.fl_addr   <= '0;
            bus.if_rvalid <= 1'b0;
            bus.ld_rvalid <= 1'b0;
            bus.if_rdata  <= '0;
            bus.ld_rdata  <= '0;
            bus.busy      <= 1'b0;
        end else begin
            bus.fl_en     <= 1'b0;
            bus.if_rvalid <= 1'b0;
            bus.ld_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.if_req || bus.ld_req) begin
                        owner      <= grant_ld ? PORT_LD : PORT_IF;
                        last_grant <= grant_ld ? PORT_LD : PORT_IF;
                        bus.fl_addr <= grant_ld ? bus.ld_addr[FL_AW+1:2]
                                                : bus.if_addr[FL_AW+1:2];
                        bus.fl_en  <= 1'b1;
                        bus.busy   <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    lat_cnt <= LAT_LOAD;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt != 4'd0) begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end else begin
                        if (owner == PORT_LD) begin
                            bus.ld_rdata  <= bus.fl_rdata;
                            bus.ld_rvalid <= 1'b1;
                        end else begin
                            bus.if_rdata  <= bus.fl_rdata;
                            bus.if_rvalid <= 1'b1;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_flash_arbiter.sv
// Directed bench for flash_arbiter: one instance at READ_LAT=1 and one at
// READ_LAT=3, each fed by a small pipelined flash model.
module tb_flash_arbiter;
    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    localparam logic [31:0] BAD = 32'hBAD0_BAD0;

    flash_arbiter_if #(.AW(32), .DW(32), .FL_AW(12)) bus_a ();
    flash_arbiter_if #(.AW(32), .DW(32), .FL_AW(12)) bus_b ();

    flash_arbiter #(.AW(32), .DW(32), .FL_AW(12), .READ_LAT(1)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave)
    );
    flash_arbiter #(.AW(32), .DW(32), .FL_AW(12), .READ_LAT(3)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flash contents: word i = 0xA5000000 | i, with a few test words overridden.
    logic [31:0] mem [16];
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'hA500_0000 | 32'(i);
        mem[4] = 32'h0050_0093;
        mem[1] = 32'hDEAD_BEEF;
    end

    // Flash models: data is driven only READ_LAT cycles after fl_en, BAD otherwise.
    logic [31:0] pipe_a;
    logic        val_a = 1'b0;
    always @(posedge clk) begin
        val_a  <= bus_a.fl_en;
        pipe_a <= mem[bus_a.fl_addr[3:0]];
    end
    assign bus_a.fl_rdata = val_a ? pipe_a : BAD;

    logic [31:0] pipe_b [3];
    logic [2:0]  val_b = 3'b000;
    always @(posedge clk) begin
        val_b     <= {val_b[1:0], bus_b.fl_en};
        pipe_b[0] <= mem[bus_b.fl_addr[3:0]];
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign bus_b.fl_rdata = val_b[2] ? pipe_b[2] : BAD;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        bus_a.if_req = 1'b0; bus_a.if_addr = '0; bus_a.ld_req = 1'b0; bus_a.ld_addr = '0;
        bus_b.if_req = 1'b0; bus_b.if_addr = '0; bus_b.ld_req = 1'b0; bus_b.ld_addr = '0;
        tick();
        tick();

        // Reset values
        check("rst_busy",      32'(bus_a.busy),      32'd0);
        check("rst_fl_en",     32'(bus_a.fl_en),     32'd0);
        check("rst_fl_addr",   32'(bus_a.fl_addr),   32'd0);
        check("rst_if_rvalid", 32'(bus_a.if_rvalid), 32'd0);
        check("rst_ld_rvalid", 32'(bus_a.ld_rvalid), 32'd0);
        check("rst_if_rdata",  bus_a.if_rdata,       32'd0);
        check("rst_ld_rdata",  bus_a.ld_rdata,       32'd0);

        // Single fetch, READ_LAT=1: fl_en in cycle 1, rvalid in cycle 3
        reset = 1'b1;
        bus_a.if_req = 1'b1; bus_a.if_addr = 32'h0000_0010;
        tick();
        check("t1_fl_en",   32'(bus_a.fl_en),   32'd1);
        check("t1_fl_addr", 32'(bus_a.fl_addr), 32'd4);
        check("t1_busy",    32'(bus_a.busy),    32'd1);
        tick();
        check("t1_fl_en_drop",  32'(bus_a.fl_en),     32'd0);
        check("t1_rvalid_early", 32'(bus_a.if_rvalid), 32'd0);
        tick();
        check("t1_if_rvalid", 32'(bus_a.if_rvalid), 32'd1);
        check("t1_if_rdata",  bus_a.if_rdata,       32'h0050_0093);
        check("t1_ld_rvalid", 32'(bus_a.ld_rvalid), 32'd0);
        bus_a.if_req = 1'b0;
        tick();
        check("t1_rvalid_pulse", 32'(bus_a.if_rvalid), 32'd0);
        check("t1_busy_idle",    32'(bus_a.busy),      32'd0);

        // Fresh reset, then both ports held: first tie to fetch, then strict alternation
        reset = 1'b0;
        tick();
        reset = 1'b1;
        bus_a.if_req = 1'b1; bus_a.if_addr = 32'h0000_0000;
        bus_a.ld_req = 1'b1; bus_a.ld_addr = 32'h0000_0008;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("rr%0d_fl_en", k),   32'(bus_a.fl_en),   32'd1);
            check($sformatf("rr%0d_fl_addr", k), 32'(bus_a.fl_addr), (k % 2 == 0) ? 32'd0 : 32'd2);
            tick();
            tick();
            check($sformatf("rr%0d_if_rvalid", k), 32'(bus_a.if_rvalid), (k % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("rr%0d_ld_rvalid", k), 32'(bus_a.ld_rvalid), (k % 2 == 0) ? 32'd0 : 32'd1);
            check($sformatf("rr%0d_rdata", k),
                  (k % 2 == 0) ? bus_a.if_rdata : bus_a.ld_rdata,
                  (k % 2 == 0) ? 32'hA500_0000 : 32'hA500_0002);
            if (k == 5) begin
                bus_a.if_req = 1'b0;
                bus_a.ld_req = 1'b0;
            end
            tick();
            check($sformatf("rr%0d_gap_busy", k), 32'(bus_a.busy), 32'd0);
        end

        // Address change after grant is ignored
        bus_a.if_req = 1'b1; bus_a.if_addr = 32'h0000_0020;
        tick();
        check("ac_fl_addr", 32'(bus_a.fl_addr), 32'd8);
        tick();
        bus_a.if_addr = 32'h0000_0040;
        tick();
        check("ac_if_rvalid", 32'(bus_a.if_rvalid), 32'd1);
        check("ac_if_rdata",  bus_a.if_rdata,       32'hA500_0008);
        bus_a.if_req = 1'b0;
        tick();

        // Reset during WAIT abandons the read
        bus_a.if_req = 1'b1; bus_a.if_addr = 32'h0000_0010;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("mr_if_rvalid", 32'(bus_a.if_rvalid), 32'd0);
        check("mr_busy",      32'(bus_a.busy),      32'd0);
        check("mr_fl_en",     32'(bus_a.fl_en),     32'd0);
        check("mr_if_rdata",  bus_a.if_rdata,       32'd0);
        reset = 1'b1;
        tick();
        check("mr_fl_en_new",   32'(bus_a.fl_en),   32'd1);
        check("mr_fl_addr_new", 32'(bus_a.fl_addr), 32'd4);
        tick();
        check("mr_no_early", 32'(bus_a.if_rvalid), 32'd0);
        tick();
        check("mr_if_rvalid_new", 32'(bus_a.if_rvalid), 32'd1);
        check("mr_if_rdata_new",  bus_a.if_rdata,       32'h0050_0093);
        bus_a.if_req = 1'b0;
        tick();

        // READ_LAT=3: prime if_rdata, then a misaligned load
        bus_b.if_req = 1'b1; bus_b.if_addr = 32'h0000_0010;
        tick();
        check("l3_if_fl_en", 32'(bus_b.fl_en), 32'd1);
        tick(); tick(); tick();
        check("l3_if_early", 32'(bus_b.if_rvalid), 32'd0);
        tick();
        check("l3_if_rvalid", 32'(bus_b.if_rvalid), 32'd1);
        check("l3_if_rdata",  bus_b.if_rdata,       32'h0050_0093);
        bus_b.if_req = 1'b0;
        tick();
        bus_b.ld_req = 1'b1; bus_b.ld_addr = 32'h0000_0007;
        tick();
        check("l3_ld_fl_en",   32'(bus_b.fl_en),   32'd1);
        check("l3_ld_fl_addr", 32'(bus_b.fl_addr), 32'd1);
        for (int c = 2; c <= 4; c++) begin
            tick();
            check($sformatf("l3_ld_quiet_c%0d", c), 32'(bus_b.ld_rvalid), 32'd0);
        end
        tick();
        check("l3_ld_rvalid",   32'(bus_b.ld_rvalid), 32'd1);
        check("l3_ld_rdata",    bus_b.ld_rdata,       32'hDEAD_BEEF);
        check("l3_if_rdata_hold", bus_b.if_rdata,     32'h0050_0093);
        check("l3_if_rvalid_0", 32'(bus_b.if_rvalid), 32'd0);
        bus_b.ld_req = 1'b0;
        tick();
        check("l3_busy_idle", 32'(bus_b.busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
